multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle ARC MIPS core.
- Sequences one instruction over 3-5+ states: fetch, decode, execute, memory, writeback.
- Drives the ALU-control inputs (AluOp, Other) plus all mux, write-enable and memory strobes.
- Sits beside alu_control and consumes its jump-register flag. A wait-state counter enforces a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory state waits for i_con_MemReady before aborting.
- CNT_W, 8: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_con_Opcode  in  6  instruction[31:26] from IR.
- i_con_jumpreg  in  1  alu_control jump-register flag, valid when AluOp=2'b10.
- i_con_MemReady  in  1  memory access complete this cycle.
- o_con_PcWrite  out  1  unconditional PC load.
- o_con_PcWriteCond  out  1  branch PC load, qualified by the datapath zero flag.
- o_con_PcSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register rs.
- o_con_IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- o_con_MemRead  out  1  memory read strobe.
- o_con_MemWrite  out  1  memory write strobe.
- o_con_IrWrite  out  1  load IR.
- o_con_MemToReg  out  1  writeback data: 1 = MDR.
- o_con_RegWrite  out  1  register file write.
- o_con_RegDst  out  2  0 = rt, 1 = rd, 2 = r31.
- o_con_AluSrcA  out  1  0 = PC, 1 = rs.
- o_con_AluSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- o_con_AluOp  out  2  to alu_control.
- o_con_Other  out  4  to alu_control, I/J sub-op.
- o_con_MemErr  out  1  one-cycle pulse on memory timeout.
- o_con_Illegal  out  1  one-cycle pulse on an undefined opcode.
- o_con_State  out  4  current state, for debug.

Behaviour:
- Reset (async, i_rst_n=0):
  - State = FETCH, wait counter = 0.
  - All outputs are Moore, decoded from state only, except the MemErr/Illegal registered pulses.
  - Every output is 0 in reset, including AluOp=0 and Other=0.
- Reset asserted mid-instruction abandons it with no further strobes.
- Default outputs in every state are 0. Only the listed signals assert.

States and transitions:
- FETCH (0): MemRead, IorD=0, AluSrcA=0, AluSrcB=1, AluOp=0.
  - IrWrite and PcWrite (PcSource=0) assert only in the cycle i_con_MemReady=1.
  - Goes to DECODE on MemReady; otherwise holds.
- DECODE (1): AluSrcA=0, AluSrcB=3, AluOp=0 (branch target into ALUOut). Dispatch on Opcode:
  - 0 -> REXEC.
  - 35 or 43 -> MEMADR.
  - 4 or 5 -> BRANCH.
  - 8, 9, 10, 11, 12, 13, 14, 15 -> IEXEC.
  - 2 -> JUMP.
  - 3 -> JAL.
  - Any other opcode -> FETCH, with o_con_Illegal pulsed the next cycle.
- MEMADR (2): AluSrcA=1, AluSrcB=2, AluOp=0. Goes to MEMRD if opcode 35, else MEMWR.
- MEMRD (3): MemRead, IorD=1. Goes to MEMWB on MemReady.
- MEMWB (4): RegWrite, RegDst=0, MemToReg=1. Goes to FETCH.
- MEMWR (5): MemWrite, IorD=1. Goes to FETCH on MemReady.
- REXEC (6): AluSrcA=1, AluSrcB=0, AluOp=2.
  - If i_con_jumpreg: goes to JR.
  - Else: goes to RWB.
- RWB (7): AluSrcA=1, AluSrcB=0, AluOp=2, RegWrite, RegDst=1. Goes to FETCH.
- BRANCH (8): AluSrcA=1, AluSrcB=0, PcWriteCond, PcSource=1. Goes to FETCH.
  - Opcode 4: AluOp=1.
  - Opcode 5: AluOp=3, Other=5.
- IEXEC (9): AluSrcA=1, AluSrcB=2, AluOp=3. Other by opcode:
  - 8 or 9 -> 0.
  - 12 -> 1.
  - 13 -> 2.
  - 14 -> 3.
  - 10 or 11 -> 6.
  - 15 -> 7.
  - Goes to IWB.
- IWB (10): same ALU controls as IEXEC, plus RegWrite, RegDst=0. Goes to FETCH.
- JUMP (11): PcWrite, PcSource=2. Goes to FETCH.
- JAL (12): AluOp=3, Other=8, RegWrite, RegDst=2, PcWrite, PcSource=2. Goes to FETCH.
- JR (13): PcWrite, PcSource=3. Goes to FETCH.
- Codes 14-15 are unreachable. If ever entered, go to FETCH.

Memory wait counter (FETCH, MEMRD, MEMWR):
- Cleared on entry to any memory state and whenever MemReady=1.
- Increments each waiting cycle.
- If it reaches MEM_TIMEOUT with MemReady still 0:
  - Next state = FETCH, o_con_MemErr pulses 1 cycle, counter clears.
  - No IrWrite, PcWrite, MemWrite or RegWrite occurs.
- MemReady in the same cycle as the timeout compare: MemReady wins and the access completes normally.
- The counter saturates and never wraps.

Latency with MemReady=1 on first request:
- R-type: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- I-type ALU: 4 cycles.
- branch, j, jal, jr: 3-4 cycles (jr is 4: FETCH-DECODE-REXEC-JR).

Test Plan:
- Reset then release with MemReady=1 and Opcode=35 -> State sequence 0,1,2,3,4,0. RegWrite=1 and MemToReg=1 only in state 4. All outputs 0 during reset.
- Opcode=0 with jumpreg=1 in REXEC -> states 0,1,6,13. In state 13: PcWrite=1, PcSource=3, RegWrite=0.
- Opcode=13 (ori) -> in IEXEC and IWB: AluOp=3, Other=2. RegWrite=1 only in IWB. Opcode=5 (bne) -> BRANCH with AluOp=3, Other=5, PcWriteCond=1.
- MemReady held 0 in FETCH with MEM_TIMEOUT=4 -> MemErr pulses once after 4 wait cycles. State returns to 0. No IrWrite seen. MemReady=1 on cycle 4 instead -> no MemErr, proceeds to DECODE.
- Opcode=63 -> DECODE returns to FETCH, Illegal=1 for exactly 1 cycle, no write strobes.
- Assert i_rst_n=0 asynchronously in MEMWR mid-wait -> MemWrite drops immediately, before the next i_clk edge. State=0 and counter=0 after release.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller side uses the slave modport; the datapath side uses master.
interface multicycle_ctrl_if;
   logic [5:0] i_con_Opcode;
   logic       i_con_jumpreg;
   logic       i_con_MemReady;

   logic       o_con_PcWrite;
   logic       o_con_PcWriteCond;
   logic [1:0] o_con_PcSource;
   logic       o_con_IorD;
   logic       o_con_MemRead;
   logic       o_con_MemWrite;
   logic       o_con_IrWrite;
   logic       o_con_MemToReg;
   logic       o_con_RegWrite;
   logic [1:0] o_con_RegDst;
   logic       o_con_AluSrcA;
   logic [1:0] o_con_AluSrcB;
   logic [1:0] o_con_AluOp;
   logic [3:0] o_con_Other;
   logic       o_con_MemErr;
   logic       o_con_Illegal;
   logic [3:0] o_con_State;

   modport slave (
      input  i_con_Opcode, i_con_jumpreg, i_con_MemReady,
      output o_con_PcWrite, o_con_PcWriteCond, o_con_PcSource, o_con_IorD,
             o_con_MemRead, o_con_MemWrite, o_con_IrWrite, o_con_MemToReg,
             o_con_RegWrite, o_con_RegDst, o_con_AluSrcA, o_con_AluSrcB,
             o_con_AluOp, o_con_Other, o_con_MemErr, o_con_Illegal, o_con_State
   );

   modport master (
      output i_con_Opcode, i_con_jumpreg, i_con_MemReady,
      input  o_con_PcWrite, o_con_PcWriteCond, o_con_PcSource, o_con_IorD,
             o_con_MemRead, o_con_MemWrite, o_con_IrWrite, o_con_MemToReg,
             o_con_RegWrite, o_con_RegDst, o_con_AluSrcA, o_con_AluSrcB,
             o_con_AluOp, o_con_Other, o_con_MemErr, o_con_Illegal, o_con_State
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: fetch/decode/execute/memory/
// writeback sequencing, with a wait counter that aborts stalled memory accesses.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input logic              i_clk,
   input logic              i_rst_n,
   multicycle_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
      StMemWb  = 4'd4,  StMemWr  = 4'd5,  StRExec  = 4'd6,  StRWb    = 4'd7,
      StBranch = 4'd8,  StIExec  = 4'd9,  StIWb    = 4'd10, StJump   = 4'd11,
      StJal    = 4'd12, StJr     = 4'd13
   } state_e;

   // Last waiting cycle: a miss here makes the counter reach MEM_TIMEOUT.
   localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             illegal_q, illegal_d;
   logic             in_mem, timeout;
   logic [3:0]       iexec_other;

   assign in_mem  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   // MemReady has priority over the timeout compare.
   assign timeout = in_mem && !bus.i_con_MemReady && (cnt_q >= WaitLast);

   // I-type ALU sub-op for alu_control, from the opcode.
   always_comb begin
      case (bus.i_con_Opcode)
         6'd12:         iexec_other = 4'd1;
         6'd13:         iexec_other = 4'd2;
         6'd14:         iexec_other = 4'd3;
         6'd10, 6'd11:  iexec_other = 4'd6;
         6'd15:         iexec_other = 4'd7;
         default:       iexec_other = 4'd0;
      endcase
   end

   // Next state, wait counter and pulse requests.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      mem_err_d = timeout;
      illegal_d = 1'b0;
      if (in_mem && !bus.i_con_MemReady && !timeout) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      case (state_q)
         StFetch:  if (bus.i_con_MemReady) state_d = StDecode;
         StDecode: begin
            case (bus.i_con_Opcode)
               6'd0:                    state_d = StRExec;
               6'd35, 6'd43:            state_d = StMemAdr;
               6'd4, 6'd5:              state_d = StBranch;
               6'd8, 6'd9, 6'd10, 6'd11,
               6'd12, 6'd13, 6'd14, 6'd15: state_d = StIExec;
               6'd2:                    state_d = StJump;
               6'd3:                    state_d = StJal;
               default: begin
                  state_d   = StFetch;
                  illegal_d = 1'b1;
               end
            endcase
         end
         StMemAdr: state_d = (bus.i_con_Opcode == 6'd35) ? StMemRd : StMemWr;
         StMemRd: begin
            if (bus.i_con_MemReady) state_d = StMemWb;
            else if (timeout)       state_d = StFetch;
         end
         StMemWr:  if (bus.i_con_MemReady || timeout) state_d = StFetch;
         StRExec:  state_d = bus.i_con_jumpreg ? StJr : StRWb;
         StIExec:  state_d = StIWb;
         default:  state_d = StFetch;
      endcase
   end

   // State, counter and pulse registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
         illegal_q <= illegal_d;
      end
   end

   // Moore control decode; forced low while reset is held so strobes drop at once.
   always_comb begin
      bus.o_con_PcWrite     = 1'b0;
      bus.o_con_PcWriteCond = 1'b0;
      bus.o_con_PcSource    = 2'd0;
      bus.o_con_IorD        = 1'b0;
      bus.o_con_MemRead     = 1'b0;
      bus.o_con_MemWrite    = 1'b0;
      bus.o_con_IrWrite     = 1'b0;
      bus.o_con_MemToReg    = 1'b0;
      bus.o_con_RegWrite    = 1'b0;
      bus.o_con_RegDst      = 2'd0;
      bus.o_con_AluSrcA     = 1'b0;
      bus.o_con_AluSrcB     = 2'd0;
      bus.o_con_AluOp       = 2'd0;
      bus.o_con_Other       = 4'd0;
      if (i_rst_n) begin
         case (state_q)
            StFetch: begin
               bus.o_con_MemRead = 1'b1;
               bus.o_con_AluSrcB = 2'd1;
               bus.o_con_IrWrite = bus.i_con_MemReady;
               bus.o_con_PcWrite = bus.i_con_MemReady;
            end
            StDecode: bus.o_con_AluSrcB = 2'd3;
            StMemAdr: begin
               bus.o_con_AluSrcA = 1'b1;
               bus.o_con_AluSrcB = 2'd2;
            end
            StMemRd: begin
               bus.o_con_MemRead = 1'b1;
               bus.o_con_IorD    = 1'b1;
            end
            StMemWb: begin
               bus.o_con_RegWrite = 1'b1;
               bus.o_con_MemToReg = 1'b1;
            end
            StMemWr: begin
               bus.o_con_MemWrite = 1'b1;
               bus.o_con_IorD     = 1'b1;
            end
            StRExec: begin
               bus.o_con_AluSrcA = 1'b1;
               bus.o_con_AluOp   = 2'd2;
            end
            StRWb: begin
               bus.o_con_AluSrcA  = 1'b1;
               bus.o_con_AluOp    = 2'd2;
               bus.o_con_RegWrite = 1'b1;
               bus.o_con_RegDst   = 2'd1;
            end
            StBranch: begin
               bus.o_con_AluSrcA     = 1'b1;
               bus.o_con_PcWriteCond = 1'b1;
               bus.o_con_PcSource    = 2'd1;
               if (bus.i_con_Opcode == 6'd4) begin
                  bus.o_con_AluOp = 2'd1;
               end else if (bus.i_con_Opcode == 6'd5) begin
                  bus.o_con_AluOp = 2'd3;
                  bus.o_con_Other = 4'd5;
               end
            end
            StIExec, StIWb: begin
               bus.o_con_AluSrcA  = 1'b1;
               bus.o_con_AluSrcB  = 2'd2;
               bus.o_con_AluOp    = 2'd3;
               bus.o_con_Other    = iexec_other;
               bus.o_con_RegWrite = (state_q == StIWb);
            end
            StJump: begin
               bus.o_con_PcWrite  = 1'b1;
               bus.o_con_PcSource = 2'd2;
            end
            StJal: begin
               bus.o_con_AluOp    = 2'd3;
               bus.o_con_Other    = 4'd8;
               bus.o_con_RegWrite = 1'b1;
               bus.o_con_RegDst   = 2'd2;
               bus.o_con_PcWrite  = 1'b1;
               bus.o_con_PcSource = 2'd2;
            end
            StJr: begin
               bus.o_con_PcWrite  = 1'b1;
               bus.o_con_PcSource = 2'd3;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_con_MemErr  = mem_err_q;
   assign bus.o_con_Illegal = illegal_q;
   assign bus.o_con_State   = state_q;

endmodule
